// File: rtl/sprite_blitter.sv
// Sprite plotter: walks an SPR_W x SPR_H ROM, emitting clipped, colour-keyed framebuffer writes.
// Latency 2 cycles per pixel regardless of content; no backpressure, start ignored while busy.
module sprite_blitter #(
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int ADDR_W      = 8,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int COLOUR_W    = 3,
  parameter int X_OFFSET    = 8,
  parameter int TRANSPARENT = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic                erase,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam logic [X_W:0]        SCR_W_V = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]        SCR_H_V = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0]        X_OFF_V = (X_W+1)'(X_OFFSET);
  localparam logic [COLOUR_W-1:0] KEY_V   = COLOUR_W'(TRANSPARENT);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [X_W:0]  origin_x;  // two's complement, negative when sprite hangs off the left edge
  logic [Y_W-1:0] origin_y;
  logic          erase_r;

  logic [X_W:0]  px;
  logic [Y_W:0]  py;
  logic          visible;
  logic          opaque;
  logic          last_px;

  assign rom_addr = {row, col};
  assign px       = origin_x + {{(X_W+1-CW){1'b0}}, col};
  assign py       = {1'b0, origin_y} + {{(Y_W+1-RW){1'b0}}, row};
  // Sign bit set means left of screen; the extra py bit catches wrap past the bottom.
  assign visible  = !px[X_W] && (px < SCR_W_V) && (py < SCR_H_V);
  assign opaque   = erase_r || (rom_data != KEY_V);
  assign last_px  = (col == {CW{1'b1}}) && (row == {RW{1'b1}});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      origin_x   <= '0;
      origin_y   <= '0;
      erase_r    <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      writeEn    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            origin_x <= {1'b0, x_in} - X_OFF_V;
            origin_y <= y_in;
            erase_r  <= erase;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            if (y_in == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: state <= WRITE;
        WRITE: begin
          x_out      <= px[X_W-1:0];
          y_out      <= py[Y_W-1:0];
          colour_out <= erase_r ? bg_colour : rom_data;
          writeEn    <= visible && opaque;
          col        <= col + 1'b1;
          if (col == {CW{1'b1}})
            row <= row + 1'b1;
          if (last_px) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: reference model fills a write scoreboard per blit.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       erase = 1'b0;
  logic [8:0] x_in = '0;
  logic [7:0] y_in = '0;
  logic [2:0] bg_colour = '0;
  logic [2:0] rom_data;
  logic [7:0] rom_addr;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic [2:0] colour_out;
  logic       writeEn, busy, done;

  logic [2:0]  rom [256];
  logic [19:0] sb [$];
  int compared = 0, mismatched = 0;
  int cyc = 0, t0 = 0, wcount = 0, first_wc = -1, last_wc = -1;

  sprite_blitter dut (
    .clk(clk), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .erase(erase), .bg_colour(bg_colour), .rom_addr(rom_addr), .rom_data(rom_data),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .writeEn(writeEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write monitor: every writeEn pulse is popped against the scoreboard.
  always @(negedge clk) begin
    logic [19:0] e;
    cyc++;
    if (writeEn === 1'b1) begin
      if (wcount == 0) first_wc = cyc - t0;
      last_wc = cyc - t0;
      wcount++;
      e = 20'hFFFFF;
      if (sb.size() > 0) e = sb.pop_front();
      chk("write_pixel", {x_out, y_out, colour_out}, e);
    end
  end

  task automatic build(input int x, input int y, input logic er, input logic [2:0] bg);
    int ox;
    ox = x - 8;
    if (y == 0) return;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int px, py;
        logic [2:0] p;
        px = ox + c;
        py = y + r;
        p  = rom[r*16 + c];
        if (px >= 0 && px < 320 && py < 240 && (er || p != 3'd0))
          sb.push_back({9'(px), 8'(py), er ? bg : p});
      end
  endtask

  task automatic run(input string tag, input int x, input int y, input logic er,
                     input logic [2:0] bg, input int exp_done, input int exp_w,
                     input int exp_first, input int exp_last,
                     input int extra_cyc, input int rst_cyc);
    int dcount, dcyc, c, limit;
    dcount = 0; dcyc = -1; c = 0;
    sb.delete();
    build(x, y, er, bg);
    @(negedge clk); #1;
    wcount = 0; first_wc = -1; last_wc = -1;
    x_in = 9'(x); y_in = 8'(y); erase = er; bg_colour = bg; start = 1'b1;
    t0 = cyc;
    limit = (rst_cyc > 0) ? rst_cyc + 20 : exp_done + 2;
    while (c < limit) begin
      @(negedge clk); #1;
      c = cyc - t0;
      if (c == 1) start = 1'b0;
      if (c == extra_cyc) start = 1'b1;
      if (c == extra_cyc + 1) start = 1'b0;
      if (done === 1'b1) begin dcount++; dcyc = c; end
      if (c == rst_cyc) resetn = 1'b0;
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        chk({tag, "_rst_outs"}, {x_out, y_out, colour_out, writeEn, busy, done}, 0);
        resetn = 1'b1;
      end
      if (rst_cyc <= 0 && c == exp_done) chk({tag, "_busy_at_done"}, busy, 1);
      if (rst_cyc <= 0 && c == exp_done + 1) chk({tag, "_busy_after"}, busy, 0);
    end
    if (rst_cyc > 0) begin
      chk({tag, "_done_count"}, dcount, 0);
      sb.delete();
    end else begin
      chk({tag, "_done_cycle"}, dcyc, exp_done);
      chk({tag, "_done_count"}, dcount, 1);
      chk({tag, "_sb_left"}, sb.size(), 0);
    end
    chk({tag, "_writes"}, wcount, exp_w);
    chk({tag, "_first_wr"}, first_wc, exp_first);
    chk({tag, "_last_wr"}, last_wc, exp_last);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 3'(i % 7 + 1);
    repeat (3) @(negedge clk);
    chk("rst_xy", {x_out, y_out}, 0);
    chk("rst_colour", colour_out, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_flags", {writeEn, busy, done}, 0);
    #1 resetn = 1'b1;

    run("opaque", 100, 50, 1'b0, 3'd0, 513, 256, 3, 513, -5, 0);
    run("right_clip", 318, 232, 1'b0, 3'd0, 513, 80, 3, 245, -5, 0);
    run("left_clip", 3, 50, 1'b0, 3'd0, 513, 176, 13, 513, -5, 0);

    for (int i = 0; i < 256; i++) rom[i] = (i % 2) ? 3'd5 : 3'd0;
    run("transp", 100, 50, 1'b0, 3'd0, 513, 128, 5, 513, -5, 0);
    run("erase", 100, 50, 1'b1, 3'b010, 513, 256, 3, 513, 10, 0);
    run("y_zero", 100, 0, 1'b0, 3'd0, 1, 0, -1, -1, -5, 0);

    for (int i = 0; i < 256; i++) rom[i] = 3'(i % 7 + 1);
    run("reset_mid", 100, 50, 1'b0, 3'd0, 0, 19, 3, 39, -5, 40);
    run("after_rst", 60, 100, 1'b0, 3'd0, 513, 256, 3, 513, -5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
